difftest_step_batcher: RTL and testbench



---
 rtl/difftest_batch_pkg.sv | 18 +
 rtl/difftest_flush_timer.sv | 30 +++
 rtl/difftest_step_batcher.sv | 210 +++++++++++++++++++++
 tb/tb_difftest_step_batcher.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/difftest_batch_pkg.sv
// Shared types and verdict constants for the difftest step batcher.
package difftest_batch_pkg;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } batch_state_e;

   localparam logic [31:0] RESP_OK    = 32'h0000_0000;
   localparam logic [31:0] RESP_LIMIT = 32'h0000_00FF;

   function automatic logic batch_outstanding(input batch_state_e s);
      return (s == ISSUE) || (s == WAIT);
   endfunction

endpackage

// File: rtl/difftest_flush_timer.sv
// Idle-cycle counter: counts while i_inc, zeroes on i_clear, flags expiry at FLUSH_TIMEOUT-1.
module difftest_flush_timer #(
   parameter int unsigned FLUSH_TIMEOUT = 256
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_inc,
   input  logic i_clear,
   output logic o_expire
);

   localparam int unsigned CW = (FLUSH_TIMEOUT > 2) ? $clog2(FLUSH_TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(FLUSH_TIMEOUT - 1);

   logic [CW-1:0] r_count;

   // Saturates at LAST so a held expiry never wraps back to zero.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc && (r_count != LAST)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expire = (r_count == LAST);

endmodule

// File: rtl/difftest_step_batcher.sv
// Batches per-cycle difftest step counts into checker requests and owns run termination.
// Optional perf counters are built when DIFFTEST_BATCH_PERF_EN is defined.
module difftest_step_batcher
   import difftest_batch_pkg::*;
#(
   parameter int unsigned STEP_WIDTH    = 8,
   parameter int unsigned BATCH_WIDTH   = 16,
   parameter int unsigned BATCH_THRESH  = 64,
   parameter int unsigned FLUSH_TIMEOUT = 256
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [STEP_WIDTH-1:0]  step,
   input  logic [63:0]            max_cycles,
   output logic                   stall,
   output logic                   req_valid,
   input  logic                   req_ready,
   output logic [BATCH_WIDTH-1:0] req_steps,
   input  logic                   resp_valid,
   input  logic [31:0]            resp_code,
   output logic [63:0]            cycle_count,
   output logic                   done,
   output logic                   fail,
   output logic                   exceeded,
   output logic [31:0]            fail_code,
   output logic [31:0]            perf_batches,
   output logic [31:0]            perf_stall_cycles
);

   localparam logic [63:0] STALL_LIMIT_64 =
      (64'd1 << BATCH_WIDTH) - 64'd1 - 64'd2 * ((64'd1 << STEP_WIDTH) - 64'd1);
   localparam logic [BATCH_WIDTH-1:0] STALL_LIMIT = STALL_LIMIT_64[BATCH_WIDTH-1:0];
   localparam logic [BATCH_WIDTH:0]   THRESH_EXT  = (BATCH_WIDTH+1)'(BATCH_THRESH);

   batch_state_e r_state, w_state_nxt;

   logic [BATCH_WIDTH-1:0] r_acc, w_acc_nxt;
   logic                   r_req_valid, w_req_valid_nxt;
   logic [BATCH_WIDTH-1:0] r_req_steps, w_req_steps_nxt;
   logic                   r_stall, w_stall_nxt;
   logic                   r_done, w_done_nxt;
   logic                   r_fail, w_fail_nxt;
   logic                   r_exceeded, w_exceeded_nxt;
   logic [31:0]            r_fail_code, w_fail_code_nxt;
   logic [63:0]            r_cycle_count;

   logic                   w_accum_en;
   logic [BATCH_WIDTH:0]   w_step_eff;
   logic [BATCH_WIDTH:0]   w_sum;
   logic                   w_limit_hit;
   logic                   w_timer_inc;
   logic                   w_timer_clear;
   logic                   w_timer_expire;

   // Steps only count while the DUT is actually running; stalled-cycle steps are dropped.
   assign w_accum_en  = enable && !r_stall && (r_state != DONE);
   assign w_step_eff  = w_accum_en ? (BATCH_WIDTH+1)'(step) : '0;
   assign w_sum       = {1'b0, r_acc} + w_step_eff;
   assign w_limit_hit = (max_cycles != '0) && (r_cycle_count >= max_cycles);

   assign w_timer_inc   = enable && (r_state == ACCUM) && (w_step_eff == '0) && (r_acc != '0);
   assign w_timer_clear = (r_state != ACCUM) || (w_step_eff != '0);

   difftest_flush_timer #(
      .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
   ) u_flush_timer (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_inc   (w_timer_inc),
      .i_clear (w_timer_clear),
      .o_expire(w_timer_expire)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ACCUM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_acc_nxt       = r_acc;
      w_req_valid_nxt = r_req_valid;
      w_req_steps_nxt = r_req_steps;
      w_stall_nxt     = r_stall;
      w_done_nxt      = r_done;
      w_fail_nxt      = r_fail;
      w_exceeded_nxt  = r_exceeded;
      w_fail_code_nxt = r_fail_code;

      if (w_accum_en) begin
         w_acc_nxt = w_sum[BATCH_WIDTH-1:0];
      end

      if (batch_outstanding(r_state) && (r_acc > STALL_LIMIT)) begin
         w_stall_nxt = 1'b1;
      end

      unique case (r_state)
         ACCUM: begin
            w_stall_nxt = 1'b0;
            if (enable && ((w_sum >= THRESH_EXT) || (w_timer_expire && (r_acc != '0)))) begin
               w_state_nxt     = ISSUE;
               w_req_steps_nxt = w_sum[BATCH_WIDTH-1:0];
               w_acc_nxt       = '0;
               w_req_valid_nxt = 1'b1;
            end
         end
         ISSUE: begin
            if (req_ready) begin
               w_req_valid_nxt = 1'b0;
               w_state_nxt     = WAIT;
            end
         end
         WAIT: begin
            if (resp_valid) begin
               if (resp_code == RESP_OK) begin
                  w_state_nxt = ACCUM;
               end else begin
                  w_state_nxt     = DONE;
                  w_done_nxt      = 1'b1;
                  w_fail_nxt      = (resp_code != RESP_LIMIT);
                  w_fail_code_nxt = resp_code;
               end
            end
         end
         DONE: begin
            w_stall_nxt = 1'b1;
         end
         default: w_state_nxt = ACCUM;
      endcase

      // The cycle limit overrides whatever the FSM chose, dropping any in-flight request.
      if (w_limit_hit && (r_state != DONE)) begin
         w_state_nxt    = DONE;
         w_done_nxt     = 1'b1;
         w_exceeded_nxt = 1'b1;
      end

      if (w_state_nxt == DONE) begin
         w_stall_nxt     = 1'b1;
         w_req_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_acc         <= '0;
         r_req_valid   <= 1'b0;
         r_req_steps   <= '0;
         r_stall       <= 1'b0;
         r_done        <= 1'b0;
         r_fail        <= 1'b0;
         r_exceeded    <= 1'b0;
         r_fail_code   <= '0;
         r_cycle_count <= '0;
      end else begin
         r_acc       <= w_acc_nxt;
         r_req_valid <= w_req_valid_nxt;
         r_req_steps <= w_req_steps_nxt;
         r_stall     <= w_stall_nxt;
         r_done      <= w_done_nxt;
         r_fail      <= w_fail_nxt;
         r_exceeded  <= w_exceeded_nxt;
         r_fail_code <= w_fail_code_nxt;
         // Frozen on the cycle the limit is seen so the count ends exactly at max_cycles.
         if (enable && (r_state != DONE) && !w_limit_hit) begin
            r_cycle_count <= r_cycle_count + 64'd1;
         end
      end
   end

`ifdef DIFFTEST_BATCH_PERF_EN
   logic [31:0] r_perf_batches;
   logic [31:0] r_perf_stall_cycles;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_perf_batches      <= '0;
         r_perf_stall_cycles <= '0;
      end else begin
         if ((r_state == ISSUE) && r_req_valid && req_ready && (r_perf_batches != '1)) begin
            r_perf_batches <= r_perf_batches + 32'd1;
         end
         if (r_stall && (r_state != DONE) && (r_perf_stall_cycles != '1)) begin
            r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
         end
      end
   end

   assign perf_batches      = r_perf_batches;
   assign perf_stall_cycles = r_perf_stall_cycles;
`else
   assign perf_batches      = '0;
   assign perf_stall_cycles = '0;
`endif

   assign stall       = r_stall;
   assign req_valid   = r_req_valid;
   assign req_steps   = r_req_steps;
   assign cycle_count = r_cycle_count;
   assign done        = r_done;
   assign fail        = r_fail;
   assign exceeded    = r_exceeded;
   assign fail_code   = r_fail_code;

endmodule

// File: tb/tb_difftest_step_batcher.sv
// Directed self-checking bench for difftest_step_batcher with hand-computed expectations.
module tb_difftest_step_batcher;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic [7:0]  step;
   logic [63:0] max_cycles;
   logic        stall;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_steps;
   logic        resp_valid;
   logic [31:0] resp_code;
   logic [63:0] cycle_count;
   logic        done;
   logic        fail;
   logic        exceeded;
   logic [31:0] fail_code;
   logic [31:0] perf_batches;
   logic [31:0] perf_stall_cycles;

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;

   always #5 clock = ~clock;

   difftest_step_batcher #(
      .STEP_WIDTH   (8),
      .BATCH_WIDTH  (16),
      .BATCH_THRESH (64),
      .FLUSH_TIMEOUT(256)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .enable           (enable),
      .step             (step),
      .max_cycles       (max_cycles),
      .stall            (stall),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_steps        (req_steps),
      .resp_valid       (resp_valid),
      .resp_code        (resp_code),
      .cycle_count      (cycle_count),
      .done             (done),
      .fail             (fail),
      .exceeded         (exceeded),
      .fail_code        (fail_code),
      .perf_batches     (perf_batches),
      .perf_stall_cycles(perf_stall_cycles)
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      enable     = 1'b0;
      step       = '0;
      max_cycles = '0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_code  = '0;
      tick(2);
      reset = 1'b0;
   endtask

   initial begin
      do_reset();
      check_eq("rst_req_valid", 64'(req_valid), 64'd0);
      check_eq("rst_req_steps", 64'(req_steps), 64'd0);
      check_eq("rst_stall", 64'(stall), 64'd0);
      check_eq("rst_done_fail_exc", {61'd0, done, fail, exceeded}, 64'd0);
      check_eq("rst_cycle_count", cycle_count, 64'd0);

      // Disabled: nothing counts, nothing issues.
      step = 8'd100;
      tick(1);
      check_eq("dis_req_valid", 64'(req_valid), 64'd0);
      check_eq("dis_cycle_count", cycle_count, 64'd0);

      // Threshold flush: 8 x 8 = 64.
      enable    = 1'b1;
      req_ready = 1'b1;
      step      = 8'd8;
      tick(7);
      check_eq("thr_before_valid", 64'(req_valid), 64'd0);
      tick(1);
      step = 8'd0;
      check_eq("thr_req_valid", 64'(req_valid), 64'd1);
      check_eq("thr_req_steps", 64'(req_steps), 64'd64);
      tick(1);
      check_eq("thr_handshake", 64'(req_valid), 64'd0);
      req_ready  = 1'b0;
      resp_valid = 1'b1;
      resp_code  = 32'h0;
      tick(1);
      resp_valid = 1'b0;
      check_eq("thr_ok_done", 64'(done), 64'd0);
      check_eq("thr_ok_stall", 64'(stall), 64'd0);
      check_eq("thr_cycle_count", cycle_count, 64'd10);

      // Timeout flush: a lone step of 3 is flushed 256 cycles later.
      step = 8'd3;
      tick(1);
      step = 8'd0;
      tick(255);
      check_eq("tmo_early_valid", 64'(req_valid), 64'd0);
      tick(1);
      check_eq("tmo_req_valid", 64'(req_valid), 64'd1);
      check_eq("tmo_req_steps", 64'(req_steps), 64'd3);
      req_ready = 1'b1;
      tick(1);
      req_ready  = 1'b0;
      resp_valid = 1'b1;
      tick(1);
      resp_valid = 1'b0;
      check_eq("tmo_back_done", 64'(done), 64'd0);

      // Backpressure: 255 per cycle with the checker not accepting.
      do_reset();
      enable = 1'b1;
      step   = 8'd255;
      tick(1);
      check_eq("bp_first_steps", 64'(req_steps), 64'd255);
      tick(256);
      check_eq("bp_no_stall_yet", 64'(stall), 64'd0);
      tick(1);
      check_eq("bp_stall", 64'(stall), 64'd1);
      tick(10);
      check_eq("bp_stall_held", 64'(stall), 64'd1);
      check_eq("bp_steps_stable", 64'(req_steps), 64'd255);
      check_eq("bp_valid_held", 64'(req_valid), 64'd1);
      step      = 8'd0;
      req_ready = 1'b1;
      tick(1);
      req_ready  = 1'b0;
      resp_valid = 1'b1;
      tick(1);
      resp_valid = 1'b0;
      check_eq("bp_accum_stall", 64'(stall), 64'd1);
      tick(1);
      check_eq("bp_reissue_valid", 64'(req_valid), 64'd1);
      check_eq("bp_no_wrap", 64'(req_steps), 64'd65535);
      check_eq("bp_stall_clear", 64'(stall), 64'd0);

      // Mismatch verdict, then a later verdict that must be ignored.
      req_ready = 1'b1;
      tick(1);
      req_ready  = 1'b0;
      resp_valid = 1'b1;
      resp_code  = 32'h5;
      tick(1);
      check_eq("mm_done", 64'(done), 64'd1);
      check_eq("mm_fail", 64'(fail), 64'd1);
      check_eq("mm_fail_code", 64'(fail_code), 64'd5);
      check_eq("mm_stall", 64'(stall), 64'd1);
      check_eq("mm_exceeded", 64'(exceeded), 64'd0);
      resp_code = 32'hFF;
      tick(1);
      resp_valid = 1'b0;
      check_eq("mm_ignored_code", 64'(fail_code), 64'd5);
      check_eq("mm_ignored_fail", 64'(fail), 64'd1);
`ifdef DIFFTEST_BATCH_PERF_EN
      check_eq("perf_batches", 64'(perf_batches), 64'd2);
`else
      check_eq("perf_batches_tied", 64'(perf_batches), 64'd0);
      check_eq("perf_stall_tied", 64'(perf_stall_cycles), 64'd0);
`endif

      // Checkpoint-limit verdict.
      do_reset();
      enable    = 1'b1;
      req_ready = 1'b1;
      step      = 8'd64;
      tick(1);
      step = 8'd0;
      check_eq("lim_req_steps", 64'(req_steps), 64'd64);
      tick(1);
      resp_valid = 1'b1;
      resp_code  = 32'hFF;
      tick(1);
      resp_valid = 1'b0;
      check_eq("lim_done", 64'(done), 64'd1);
      check_eq("lim_fail", 64'(fail), 64'd0);
      check_eq("lim_fail_code", 64'(fail_code), 64'hFF);

      // Max-cycle termination.
      do_reset();
      enable     = 1'b1;
      max_cycles = 64'd100;
      tick(99);
      check_eq("mc_count_99", cycle_count, 64'd99);
      check_eq("mc_done_early", 64'(done), 64'd0);
      tick(1);
      check_eq("mc_count_100", cycle_count, 64'd100);
      tick(1);
      check_eq("mc_done", 64'(done), 64'd1);
      check_eq("mc_exceeded", 64'(exceeded), 64'd1);
      check_eq("mc_fail", 64'(fail), 64'd0);
      check_eq("mc_stall", 64'(stall), 64'd1);
      tick(3);
      check_eq("mc_count_frozen", cycle_count, 64'd100);

      // Reset while a request is in flight with a nonzero accumulator.
      do_reset();
      enable = 1'b1;
      step   = 8'd64;
      tick(1);
      step = 8'd20;
      tick(1);
      check_eq("rmi_valid_before", 64'(req_valid), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("rmi_async_valid", 64'(req_valid), 64'd0);
      check_eq("rmi_async_steps", 64'(req_steps), 64'd0);
      check_eq("rmi_async_count", cycle_count, 64'd0);
      tick(1);
      reset = 1'b0;
      step  = 8'd10;
      tick(6);
      check_eq("rmi_fresh_no_issue", 64'(req_valid), 64'd0);
      tick(1);
      check_eq("rmi_fresh_valid", 64'(req_valid), 64'd1);
      check_eq("rmi_fresh_steps", 64'(req_steps), 64'd70);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
